// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: datapath width,
// requester count, ALU control encodings and the grant-index type.
package alu_arbiter_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int N_REQ         = 2;

  // ALU control word width and encodings understood by the external ALU.
  localparam int ALU_CTL_WIDTH = 4;

  localparam logic [ALU_CTL_WIDTH-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_AND = 4'd2;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_OR  = 4'd3;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_XOR = 4'd4;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLL = 4'd5;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SRL = 4'd6;
  localparam logic [ALU_CTL_WIDTH-1:0] ALU_SLT = 4'd7;

  // Index of the requester that most recently won arbitration.
  typedef enum logic {
    GRANT_R0 = 1'b0,
    GRANT_R1 = 1'b1
  } req_idx_e;

endpackage

// File: rtl/alu_rsp_buf.sv
// One-entry response buffer with valid/ready on the output side.
// A load on the same edge as a drain wins: the buffer refills and stays valid.
module alu_rsp_buf
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_data,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_data
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] data_q,  data_d;

  // Next-state: load has priority over drain; data holds unless loaded.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Buffer registers; reset discards any held response.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Handshake: a request transfers on a cycle where req_valid[n] and
// req_ready[n] are both 1; a response transfers on a cycle where
// rsp_valid[n] and rsp_ready[n] are both 1. req_ready is a function of
// req_valid, rsp_valid and rsp_ready; requesters must not make req_valid or
// their operands depend on req_ready, and must hold a pending op stable.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CTL_W = ALU_CTL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [CTL_W-1:0] req_ctl0,
  input  logic [CTL_W-1:0] req_ctl1,
  input  logic [XLEN-1:0]  req_a0,
  input  logic [XLEN-1:0]  req_b0,
  input  logic [XLEN-1:0]  req_a1,
  input  logic [XLEN-1:0]  req_b1,
  output logic [CTL_W-1:0] alu_ctl,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  input  logic [XLEN-1:0]  alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [XLEN-1:0]  rsp_data0,
  output logic [XLEN-1:0]  rsp_data1
);

  req_idx_e   last_grant_q, last_grant_d;
  logic [1:0] eligible;
  logic [1:0] grant;

  // A requester may issue only if its response slot is free or being drained.
  always_comb begin
    eligible = 2'b00;
    if (!rst) begin
      for (int n = 0; n < N_REQ; n++) begin
        eligible[n] = req_valid[n] & (~rsp_valid[n] | rsp_ready[n]);
      end
    end
  end

  // One-hot grant; on a tie the requester that did not win last time goes.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant_q == GRANT_R1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // last_grant follows the winner and holds on idle cycles.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant[0]) begin
      last_grant_d = GRANT_R0;
    end else if (grant[1]) begin
      last_grant_d = GRANT_R1;
    end
  end

  // Arbitration history; resets so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_R1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  // ALU operand steering; requester 0 is presented when nobody is granted.
  always_comb begin
    alu_ctl = req_ctl0;
    alu_a   = req_a0;
    alu_b   = req_b0;
    if (grant[1]) begin
      alu_ctl = req_ctl1;
      alu_a   = req_a1;
      alu_b   = req_b1;
    end
  end

  assign req_ready = grant;

  alu_rsp_buf #(.XLEN(XLEN)) u_rsp_buf0 (
    .clk       (clk),
    .rst       (rst),
    .load      (grant[0]),
    .load_data (alu_result),
    .out_ready (rsp_ready[0]),
    .out_valid (rsp_valid[0]),
    .out_data  (rsp_data0)
  );

  alu_rsp_buf #(.XLEN(XLEN)) u_rsp_buf1 (
    .clk       (clk),
    .rst       (rst),
    .load      (grant[1]),
    .load_data (alu_result),
    .out_ready (rsp_ready[1]),
    .out_valid (rsp_valid[1]),
    .out_data  (rsp_data1)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: provides the external ALU, runs directed scenarios
// and a randomized run against a queue-based reference model.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int XLEN  = 32;
  localparam int CTL_W = ALU_CTL_WIDTH;

  logic             clk;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [CTL_W-1:0] req_ctl0, req_ctl1;
  logic [XLEN-1:0]  req_a0, req_b0, req_a1, req_b1;
  logic [CTL_W-1:0] alu_ctl;
  logic [XLEN-1:0]  alu_a, alu_b, alu_result;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [XLEN-1:0]  rsp_data0, rsp_data1;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state: expected contents of each response slot,
  // who won the last arbitration, and who the model grants this cycle.
  logic [XLEN-1:0] exp_q0[$];
  logic [XLEN-1:0] exp_q1[$];
  int m_last  = 1;
  int m_grant = -1;

  alu_arbiter #(.XLEN(XLEN), .CTL_W(CTL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_ctl0   (req_ctl0),
    .req_ctl1   (req_ctl1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .alu_ctl    (alu_ctl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data0  (rsp_data0),
    .rsp_data1  (rsp_data1)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [XLEN-1:0] alu_fn(input logic [CTL_W-1:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return '0;
    endcase
  endfunction

  // External ALU
  always_comb alu_result = alu_fn(alu_ctl, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare outputs with the model, then advance the model across the edge.
  task automatic model_cycle();
    logic [1:0] elig;
    logic [1:0] exp_ready;
    elig      = 2'b00;
    exp_ready = 2'b00;
    m_grant   = -1;
    if (!rst) begin
      elig[0] = req_valid[0] && (exp_q0.size() == 0 || rsp_ready[0]);
      elig[1] = req_valid[1] && (exp_q1.size() == 0 || rsp_ready[1]);
      if (elig == 2'b11)  m_grant = (m_last == 1) ? 0 : 1;
      else if (elig[0])   m_grant = 0;
      else if (elig[1])   m_grant = 1;
      if (m_grant >= 0) exp_ready[m_grant] = 1'b1;
    end
    check("req_ready", req_ready, exp_ready);
    check("rsp_valid0", rsp_valid[0], exp_q0.size() != 0);
    check("rsp_valid1", rsp_valid[1], exp_q1.size() != 0);
    if (exp_q0.size() != 0) check("rsp_data0", rsp_data0, exp_q0[0]);
    if (exp_q1.size() != 0) check("rsp_data1", rsp_data1, exp_q1[0]);
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      m_last = 1;
    end else begin
      if (exp_q0.size() != 0 && rsp_ready[0]) void'(exp_q0.pop_front());
      if (exp_q1.size() != 0 && rsp_ready[1]) void'(exp_q1.pop_front());
      if (m_grant == 0) exp_q0.push_back(alu_fn(req_ctl0, req_a0, req_b0));
      if (m_grant == 1) exp_q1.push_back(alu_fn(req_ctl1, req_a1, req_b1));
      if (m_grant >= 0) m_last = m_grant;
    end
  endtask

  // Driver tasks: sample point is the falling edge, inputs change after rise.
  task automatic sample_point();
    @(negedge clk);
  endtask

  task automatic advance();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [CTL_W-1:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_valid[0] = v; req_ctl0 = c; req_a0 = a; req_b0 = b;
  endtask

  task automatic set_req1(input logic v, input logic [CTL_W-1:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_valid[1] = v; req_ctl1 = c; req_a1 = a; req_b1 = b;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    set_req0(1'b0, ALU_ADD, '0, '0);
    set_req1(1'b0, ALU_ADD, '0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    sample_point();
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_data0", rsp_data0, 0);
    check("reset_rsp_data1", rsp_data1, 0);
    advance();
    rst = 1'b0;

    // Single request, one-cycle latency
    set_req0(1'b1, ALU_ADD, 32'd5, 32'd7);
    sample_point();
    check("single_ready", req_ready, 2'b01);
    advance();
    req_valid = 2'b00;
    sample_point();
    check("single_rsp_valid", rsp_valid, 2'b01);
    check("single_rsp_data0", rsp_data0, 32'd12);
    advance();

    // Backpressure on requester 0; requester 1 keeps being served
    set_req0(1'b1, ALU_ADD, 32'd1, 32'd1);
    rsp_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      set_req1(1'b1, ALU_OR, $urandom, $urandom);
      sample_point();
      check("bp_ready", req_ready, 2'b10);
      check("bp_hold_data0", rsp_data0, 32'd12);
      advance();
    end
    req_valid[1] = 1'b0;

    // Drain plus refill of requester 0 in the same cycle
    rsp_ready = 2'b11;
    sample_point();
    check("refill_ready", req_ready, 2'b01);
    advance();
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    sample_point();
    check("refill_rsp_valid0", rsp_valid[0], 1'b1);
    check("refill_rsp_data0", rsp_data0, 32'd2);
    advance();

    // Fill buffer 1 so both slots are full, then reset mid-operation
    set_req1(1'b1, ALU_AND, 32'hFF, 32'h0F);
    sample_point();
    advance();
    check("both_full", rsp_valid, 2'b11);
    rst = 1'b1;
    set_req0(1'b1, ALU_SUB, 32'd10, 32'd3);
    set_req1(1'b1, ALU_XOR, 32'hF0, 32'hFF);
    sample_point();
    check("rst_req_ready", req_ready, 2'b00);
    advance();
    sample_point();
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_req_ready2", req_ready, 2'b00);
    advance();
    rst       = 1'b0;
    rsp_ready = 2'b11;

    // Tie: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      sample_point();
      check("tie_order", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i == 2) begin
        check("tie_rsp_data0", rsp_data0, 32'd7);
        check("tie_rsp_data1", rsp_data1, 32'h0F);
      end
      advance();
    end

    // Randomized traffic; pending ops are held until accepted
    req_valid = 2'b00;
    m_grant   = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (!req_valid[0] || m_grant == 0)
        set_req0($urandom_range(0, 3) != 0, CTL_W'($urandom_range(0, 8)),
                 $urandom, $urandom);
      if (!req_valid[1] || m_grant == 1)
        set_req1($urandom_range(0, 3) != 0, CTL_W'($urandom_range(0, 8)),
                 $urandom, $urandom);
      rsp_ready = 2'($urandom_range(0, 3));
      sample_point();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 32, operand and result width in bits.
REQ-002 Parameter CTL_W, default `ALU_CTL_WIDTH, ALU control word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid[1:0]  input  2  requester n presents an operation.
REQ-006 req_ready[1:0]  output  2  requester n's operation is accepted this cycle.
REQ-007 req_ctl0, req_ctl1  input  CTL_W each  ALU control word per requester.
REQ-008 req_a0, req_b0, req_a1, req_b1  input  XLEN each  operands per requester.
REQ-009 alu_ctl  output  CTL_W  control word driven to the shared ALU.
REQ-010 alu_a, alu_b  output  XLEN each  operands driven to the shared ALU.
REQ-011 alu_result  input  XLEN  combinational ALU result for alu_ctl/alu_a/alu_b.
REQ-012 rsp_valid[1:0]  output  2  response buffer n holds a result.
REQ-013 rsp_ready[1:0]  input  2  requester n consumes its response this cycle.
REQ-014 rsp_data0, rsp_data1  output  XLEN each  buffered result per requester.

Function
REQ-015 Requester n is eligible when req_valid[n]=1 and (rsp_valid[n]=0 or rsp_ready[n]=1).
REQ-016 At most one req_ready bit shall be 1 per cycle; req_ready[n]=1 only if n is eligible.
REQ-017 One eligible requester: granted.
REQ-018 Two eligible requesters: grant the one not recorded in last_grant; last_grant resets to 1, so requester 0 wins the first tie.
REQ-019 last_grant updates to the granted index only on a grant; it holds when no grant occurs.
REQ-020 alu_ctl/alu_a/alu_b: driven combinationally from the granted requester; from requester 0 when no grant. Value is don't-care when no grant.
REQ-021 On a grant to n, alu_result is captured into rsp_data n at the clock edge; rsp_valid[n]=1 the next cycle. Latency is 1 cycle.
REQ-022 rsp_valid[n] clears on an edge with rsp_valid[n]=1, rsp_ready[n]=1, and no new grant to n.
REQ-023 Same-cycle drain and grant to n: buffer reloads with the new result; rsp_valid[n] stays 1.
REQ-024 rsp_valid[n]=1 and rsp_ready[n]=0: rsp_data n holds stable and n is ineligible; the other requester is served normally.
REQ-025 req_ready depends combinationally on req_valid and rsp_ready; req_valid/operands shall not depend on req_ready (requester obligation).
REQ-026 A requester with req_valid=1 and req_ready=0 keeps its operation pending; arbitration re-evaluates every cycle.
REQ-027 With both requesters continuously eligible, grants alternate 0,1,0,1; starvation is impossible.

Reset
REQ-028 On rst=1 at an edge: rsp_valid=2'b00, rsp_data0/1=0, last_grant=1.
REQ-029 While rst=1, req_ready=2'b00.
REQ-030 Reset mid-operation discards buffered responses; no response appears after reset deasserts without a new grant.

Structure
REQ-031 XLEN default and the requester count (2) live in a shared package or defs file alongside the ALU defs; ALU control encodings stay in the existing ALU defs.
REQ-032 One sub-module, alu_rsp_buf (1-entry response buffer with valid/ready), is instantiated once per requester.
REQ-033 The ALU itself is external; alu_arbiter contains no arithmetic.

Verification
REQ-034 Single request: rst released; req_valid=01, ctl=ALU_ADD, a=5, b=7 -> req_ready=01 same cycle; next cycle rsp_valid=01, rsp_data0=12.
REQ-035 Tie: both valid every cycle (r0 ALU_SUB 10,3; r1 ALU_XOR 0xF0,0xFF), rsp_ready=11 -> grant order 0,1,0,1; rsp_data0=7, rsp_data1=0x0F.
REQ-036 Backpressure: rsp_ready[0]=0 after first response -> r0 stalled with rsp_data0 stable; r1 granted every cycle while valid.
REQ-037 Drain plus refill: rsp_valid[0]=1, rsp_ready[0]=1, new r0 request ALU_ADD 1,1 -> rsp_valid[0] stays 1; rsp_data0=2 next cycle.
REQ-038 Mid-operation reset: assert rst with both buffers full -> next cycle rsp_valid=00, req_ready=00; after release, first tie grants r0.
REQ-039 Random stimulus with a scoreboard: every accepted op yields exactly one response, in order, with the reference-model result; both valid bits never lost.
